// File: rtl/xbar_port_scheduler_if.sv
// Handshake bundle between the input channels, one crossbar output port and its scheduler.
// The master modport is the environment side; the slave modport is the scheduler.
interface xbar_port_scheduler_if #(
  parameter int P_CHANNEL_NUM = 4,
  parameter int P_DATA_WIDTH  = 64
);
  logic [P_CHANNEL_NUM-1:0]              i_req;
  logic [P_CHANNEL_NUM-1:0]              i_valid;
  logic [P_CHANNEL_NUM-1:0]              i_last;
  logic [P_CHANNEL_NUM*P_DATA_WIDTH-1:0] i_data;
  logic [P_CHANNEL_NUM-1:0]              o_ready;
  logic                                  o_valid;
  logic                                  o_last;
  logic [P_DATA_WIDTH-1:0]               o_data;
  logic                                  i_ready;

  modport master (
    output i_req, i_valid, i_last, i_data, i_ready,
    input  o_ready, o_valid, o_last, o_data
  );

  modport slave (
    input  i_req, i_valid, i_last, i_data, i_ready,
    output o_ready, o_valid, o_last, o_data
  );
endinterface

// File: rtl/xbar_port_scheduler.sv
// Round-robin packet scheduler for one crossbar output port: locks a grant for a whole
// packet, muxes the winner's beat stream to the port, and drops stalled owners via a watchdog.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; arbitrate among i_req and lock the winner
// XFER    | o_grant owns the port until its last beat, watchdog, or flush
module xbar_port_scheduler #(
  parameter int P_CHANNEL_NUM = 4,
  parameter int P_DATA_WIDTH  = 64,
  parameter int P_TIMEOUT     = 1024,
  parameter int P_CNT_WIDTH   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  xbar_port_scheduler_if.slave     bus,
  output logic [P_CHANNEL_NUM-1:0] o_grant,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int P_N = P_CHANNEL_NUM;
  localparam logic [P_N-1:0] LP_PTR_INIT = P_N'(1);
  localparam bit LP_WD_EN = (P_TIMEOUT != 0);
  localparam logic [P_CNT_WIDTH-1:0] LP_WD_LAST =
    P_CNT_WIDTH'((P_TIMEOUT > 0) ? (P_TIMEOUT - 1) : 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                 state;
  logic [P_N-1:0]         ptr;
  logic [P_CNT_WIDTH-1:0] wd_cnt;
  logic [2*P_N-1:0]       dbl_req;
  logic [2*P_N-1:0]       dbl_gnt;
  logic [P_N-1:0]         arb_gnt;
  logic [P_N-1:0]         ptr_next;
  logic                   accept;
  logic                   wd_hit;

  // Subtracting the one-hot pointer clears the lowest request at/above it and
  // borrows through everything below; the halves fold the wrap-around back in.
  always_comb begin
    dbl_req = {bus.i_req, bus.i_req};
    dbl_gnt = dbl_req & ~(dbl_req - {{P_N{1'b0}}, ptr});
    arb_gnt = dbl_gnt[P_N-1:0] | dbl_gnt[2*P_N-1:P_N];
  end

  always_comb begin
    bus.o_valid = |(bus.i_valid & o_grant);
    bus.o_last  = |(bus.i_last & o_grant);
    bus.o_ready = o_grant & {P_N{bus.i_ready}};
    bus.o_data  = '0;
    for (int i = 0; i < P_N; i++) begin
      bus.o_data = bus.o_data |
        (bus.i_data[i*P_DATA_WIDTH +: P_DATA_WIDTH] & {P_DATA_WIDTH{o_grant[i]}});
    end
  end

  assign accept   = bus.o_valid & bus.i_ready;
  assign wd_hit   = LP_WD_EN && (wd_cnt == LP_WD_LAST);
  assign ptr_next = {o_grant[P_N-2:0], o_grant[P_N-1]};
  assign o_busy   = (state == ST_XFER);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      ptr       <= LP_PTR_INIT;
      o_grant   <= '0;
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else if (i_flush) begin
      state     <= ST_IDLE;
      ptr       <= LP_PTR_INIT;
      o_grant   <= '0;
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|bus.i_req) begin
            o_grant <= arb_gnt;
            wd_cnt  <= '0;
            state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            wd_cnt <= '0;
            if (bus.o_last) begin
              ptr     <= ptr_next;
              o_grant <= '0;
              state   <= ST_IDLE;
            end
          end else if (wd_hit) begin
            // Stalled owner: release exactly like a packet end, but flag it.
            o_timeout <= 1'b1;
            ptr       <= ptr_next;
            o_grant   <= '0;
            wd_cnt    <= '0;
            state     <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + P_CNT_WIDTH'(1);
          end
        end
        default: begin
          o_grant <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/xbar_port_scheduler.md
Name: xbar_port_scheduler

Overview:
- Per-output-port packet scheduler for the crossbar.
- Shares one output port among P_CHANNEL_NUM input channels using round-robin arbitration with packet-level grant lock.
- Muxes the granted input's valid/data/last stream to the port with valid/ready handshake.
- Watchdog releases a grant whose owner stalls.

Parameters:
P_CHANNEL_NUM, 4, number of requesting input channels (>=2)
P_DATA_WIDTH, 64, beat data width in bits
P_TIMEOUT, 1024, max consecutive XFER cycles without an accepted beat before forced release; 0 disables watchdog
P_CNT_WIDTH, 16, watchdog counter width; must satisfy 2^P_CNT_WIDTH > P_TIMEOUT

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_req  in  P_CHANNEL_NUM  bit n: channel n has a packet pending for this port
i_valid  in  P_CHANNEL_NUM  per-channel beat valid
i_last  in  P_CHANNEL_NUM  per-channel last beat of packet
i_data  in  P_CHANNEL_NUM*P_DATA_WIDTH  per-channel data; channel n occupies bits [n*W +: W]
o_ready  out  P_CHANNEL_NUM  per-channel ready; only granted bit can be 1
o_valid  out  1  port beat valid
o_last  out  1  port last beat
o_data  out  P_DATA_WIDTH  port data
i_ready  in  1  downstream ready for port beat
o_grant  out  P_CHANNEL_NUM  registered one-hot grant; 0 when idle
o_busy  out  1  1 while in XFER
o_timeout  out  1  one-cycle pulse on watchdog release
i_flush  in  1  synchronous: reset priority pointer to 1, abort any grant, go IDLE

Behaviour:
- Reset values:
  - state=IDLE, pointer=1 (one-hot, channel 0 highest priority), o_grant=0, watchdog count=0.
  - o_busy=0, o_timeout=0, o_valid=0, o_last=0, o_data=0, o_ready=0.
- Arbitration (combinational): grant = first set bit of i_req at or above pointer position, wrapping modulo P_CHANNEL_NUM. Implemented as double-width request minus pointer, AND with inverted difference, then OR the two halves. No request gives grant 0.
- FSM states: IDLE, XFER.
- IDLE:
  - If |i_req: o_grant <= computed grant; state <= XFER next edge.
  - Arbitration latency is 1 cycle, so the first beat can transfer the cycle after the request is seen.
- XFER, with g = o_grant (registered):
  - o_valid = |(i_valid & g); o_last = |(i_last & g); o_data = slice of i_data selected by g. All combinational from registered g.
  - o_ready = g & {P_CHANNEL_NUM{i_ready}}.
  - Beat accepted when o_valid & i_ready.
  - i_req is ignored while in XFER; the grant is locked until release.
- Release on accepted beat with o_last=1:
  - pointer <= g rotated left by 1, so the channel after the winner gets top priority.
  - o_grant <= 0; state <= IDLE.
  - One idle bubble cycle between back-to-back packets.
- Watchdog:
  - Count increments each XFER cycle with no accepted beat; clears on accepted beat and on entering XFER.
  - When count == P_TIMEOUT-1 and no beat is accepted that cycle: o_timeout=1 next cycle, pointer rotates as for a normal release, o_grant <= 0, state <= IDLE.
  - Disabled when P_TIMEOUT=0.
- Simultaneous events:
  - i_flush has priority over release and timeout: pointer <= 1, o_grant <= 0, state <= IDLE, no o_timeout pulse.
  - A last beat accepted in the same cycle as timeout expiry counts as a normal release; no o_timeout pulse.
- Async reset mid-packet: immediate return to reset values. The partial packet is not completed; upstream must discard it.
- Single-beat packet (valid & last on first XFER cycle with i_ready=1): XFER lasts exactly 1 cycle.

Test Plan:
- Reset, i_req=4'b0110: o_grant=4'b0010 one cycle later. After its last beat, pointer=4'b0100; next packet is granted to ch2, o_grant=4'b0100.
- All four channels request continuously, 1-beat packets, i_ready=1: grant sequence 0001,0010,0100,1000,0001, each XFER 1 cycle with one IDLE cycle between.
- Ch1 granted with a 4-beat packet, i_ready toggling 1,0,1,0: exactly 4 beats are accepted with data in order. o_ready[0,2,3] stay 0 throughout; ch3 raising i_req mid-packet does not change o_grant.
- P_TIMEOUT=8, ch2 granted with i_valid[2]=0: o_timeout pulses on the 9th XFER cycle, o_grant=0, and ch3 wins the next arbitration if it is requesting.
- i_flush asserted mid-packet on ch3: next cycle o_grant=0 and o_busy=0, and with all channels requesting ch0 is granted next.
- Async i_rst asserted during XFER: all outputs are 0 immediately; after deassert with i_req=4'b1000, o_grant=4'b1000.
